code_emitter: RTL

CODE_EMITTER -- requirements
Module: code_emitter

---
 rtl/code_sel_pkg.sv | 19 +
 rtl/code_emitter_if.sv | 18 +
 rtl/lowest_set_enc.sv | 30 +++
 rtl/code_emitter.sv | 104 ++++++++++
 4 files changed

// File: rtl/code_sel_pkg.sv
// Shared definitions for the code emitter: parameter defaults and FSM state type.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package code_sel_pkg;

  // Default number of selectable codes (code values 1..NUM_CODES).
  localparam int NUM_CODES_DEF = 18;
  // Default code width; must satisfy 2**CODE_W > NUM_CODES.
  localparam int CODE_W_DEF    = 6;
  // Width of the transferred-codes counter.
  localparam int CNT_W         = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : code_sel_pkg

// File: rtl/code_emitter_if.sv
// Valid/ready code stream from the emitter to its consumer.
// Latency: n/a (wires only).
// Backpressure: consumer holds data_rdy_i low to stall; source keeps data_o stable.
//
// Signals:
//   data_o      emitted code value, 0 when not valid
//   data_val_o  data_o valid
//   data_rdy_i  consumer accepts; transfer when valid and ready are both high
interface code_emitter_if #(
  parameter int CODE_W = code_sel_pkg::CODE_W_DEF
);
  logic [CODE_W-1:0] data_o;
  logic              data_val_o;
  logic              data_rdy_i;

  modport master (output data_o, output data_val_o, input data_rdy_i);
  modport slave  (input data_o, input data_val_o, output data_rdy_i);
endinterface : code_emitter_if

// File: rtl/lowest_set_enc.sv
// Finds the index of the lowest set bit of a mask.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   mask_i   input mask
//   idx_o    index of the lowest set bit (0 when mask is zero)
//   found_o  high when at least one bit is set
module lowest_set_enc #(
  parameter int W     = 18,
  parameter int IDX_W = 6
) (
  input  logic [W-1:0]     mask_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the top down so the last hit, the lowest set bit, wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule : lowest_set_enc

// File: rtl/code_emitter.sv
// Emits the codes selected by a latched mask, lowest code first, on a valid/ready stream.
// Latency: first code valid the cycle after start is sampled; one code per cycle when ready is held high.
// Backpressure: data_rdy_i low holds the current code stable; nothing is dropped.
//
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   mask_i         request mask, bit k requests code k+1 (latched on accepted start)
//   start_i        start pulse, only honoured in IDLE
//   emit_if        code stream (data_o / data_val_o / data_rdy_i)
//   busy_o         high outside IDLE
//   done_o         one-cycle pulse at the end of a sequence
//   sent_cnt_o     codes transferred in the current or last sequence
module code_emitter
  import code_sel_pkg::*;
#(
  parameter int NUM_CODES = NUM_CODES_DEF,
  parameter int CODE_W    = CODE_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CODES-1:0] mask_i,
  input  logic                 start_i,
  code_emitter_if.master       emit_if,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     sent_cnt_o
);

  state_e               state_q, state_d;
  logic [NUM_CODES-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]     sent_cnt_q, sent_cnt_d;

  logic [CODE_W-1:0]    low_idx;
  logic                 low_found;
  logic                 xfer;

  lowest_set_enc #(
    .W     (NUM_CODES),
    .IDX_W (CODE_W)
  ) u_enc (
    .mask_i  (pending_q),
    .idx_o   (low_idx),
    .found_o (low_found)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      sent_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      sent_cnt_q <= sent_cnt_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    pending_d          = pending_q;
    sent_cnt_d         = sent_cnt_q;
    emit_if.data_o     = '0;
    emit_if.data_val_o = 1'b0;
    done_o             = 1'b0;
    xfer               = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pending_d  = mask_i;
          sent_cnt_d = '0;
          state_d    = (|mask_i) ? ST_EMIT : ST_DONE;
        end
      end

      ST_EMIT: begin
        emit_if.data_val_o = 1'b1;
        emit_if.data_o     = low_idx + CODE_W'(1);
        // low_found is always set in EMIT; the guard keeps an empty mask from counting.
        xfer = emit_if.data_rdy_i & low_found;
        if (xfer) begin
          pending_d  = pending_q & ~(NUM_CODES'(1) << low_idx);
          sent_cnt_d = sent_cnt_q + CNT_W'(1);
          if (pending_d == '0) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign sent_cnt_o = sent_cnt_q;

endmodule : code_emitter
